// File: rtl/branch_history_table.sv
// branch_history_table
//   Table of 2-bit saturating branch-direction counters (00 strong NT ..
//   11 strong T, prediction = bit[1]). Lookups come from fetch, and resolves
//   come from execute in program order. An in-order FIFO remembers each
//   prediction's {index, predicted bit}, so a resolve only carries the outcome.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   lookup_valid    : predict request, accepted when lookup_ready is high
//   lookup_pc       : branch PC, table index = lookup_pc[IDX_W+1:2]
//   lookup_ready    : FIFO has room (depends on occupancy only)
//   pred_valid      : one-cycle strobe, the cycle after an accepted lookup
//   pred_taken      : predicted direction
//   pred_idx        : table index used for the prediction
//   resolve_valid   : oldest in-flight branch resolved
//   resolve_taken   : actual direction
//   mispredict      : registered pulse, popped prediction != actual
//   resolve_err     : registered pulse, resolve arrived with FIFO empty
//   inflight        : FIFO occupancy
//   mispredict_cnt  : saturating mispredict counter
module branch_history_table #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          lookup_valid,
    input  logic [PC_W-1:0]               lookup_pc,
    output logic                          lookup_ready,
    output logic                          pred_valid,
    output logic                          pred_taken,
    output logic [IDX_W-1:0]              pred_idx,
    input  logic                          resolve_valid,
    input  logic                          resolve_taken,
    output logic                          mispredict,
    output logic                          resolve_err,
    output logic [$clog2(FIFO_DEPTH):0]   inflight,
    output logic [15:0]                   mispredict_cnt
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [1:0]       ctr_q       [ENTRIES];
    logic [IDX_W-1:0] fifo_idx_q  [FIFO_DEPTH];
    logic             fifo_pred_q [FIFO_DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [OCC_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ;

    logic             pred_valid_q, pred_taken_q;
    logic [IDX_W-1:0] pred_idx_q;
    logic             mispredict_q, resolve_err_q;
    logic [15:0]      mis_cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             pop_pred;
    logic             fifo_empty;
    logic             do_push, do_pop;
    logic [1:0]       pop_cur;
    logic [1:0]       ctr_d;
    logic [1:0]       lk_cnt;
    logic             lk_pred;
    logic             mis_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

    assign occ          = wr_ptr_q - rd_ptr_q;
    assign inflight     = occ;
    assign fifo_empty   = (occ == '0);
    assign lookup_ready = (occ < OCC_W'(FIFO_DEPTH));

    assign lk_idx   = lookup_pc[IDX_W+1:2];
    assign pop_idx  = fifo_idx_q[rd_ptr_q[PTR_W-1:0]];
    assign pop_pred = fifo_pred_q[rd_ptr_q[PTR_W-1:0]];

    assign do_push  = lookup_valid && lookup_ready;
    assign do_pop   = resolve_valid && !fifo_empty;

    always_comb begin
        pop_cur = ctr_q[pop_idx];
        ctr_d   = pop_cur;
        if (resolve_taken) begin
            if (pop_cur != 2'b11) ctr_d = pop_cur + 2'd1;
        end else begin
            if (pop_cur != 2'b00) ctr_d = pop_cur - 2'd1;
        end
    end

    // Same-cycle resolve to the looked-up index: forward the updated value.
    always_comb begin
        lk_cnt = ctr_q[lk_idx];
        if (do_pop && (pop_idx == lk_idx)) lk_cnt = ctr_d;
        lk_pred = lk_cnt[1];
    end

    assign mis_d = do_pop && (pop_pred != resolve_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_STATE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_idx_q    <= '0;
            mispredict_q  <= 1'b0;
            resolve_err_q <= 1'b0;
            mis_cnt_q     <= '0;
        end else begin
            if (do_pop) begin
                ctr_q[pop_idx] <= ctr_d;
                rd_ptr_q       <= rd_ptr_q + 1'b1;
            end
            if (do_push) begin
                fifo_idx_q[wr_ptr_q[PTR_W-1:0]]  <= lk_idx;
                fifo_pred_q[wr_ptr_q[PTR_W-1:0]] <= lk_pred;
                wr_ptr_q                         <= wr_ptr_q + 1'b1;
                pred_taken_q                     <= lk_pred;
                pred_idx_q                       <= lk_idx;
            end
            pred_valid_q  <= do_push;
            mispredict_q  <= mis_d;
            resolve_err_q <= resolve_valid && fifo_empty;
            if (mis_d && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 16'd1;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_idx       = pred_idx_q;
    assign mispredict     = mispredict_q;
    assign resolve_err    = resolve_err_q;
    assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// tb_branch_history_table
//   Directed scenarios followed by a randomized phase, all checked against a
//   behavioural model: an integer array of counters plus a queue of in-flight
//   {index, predicted bit} records.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [3:0]  pred_idx;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        mispredict;
    logic        resolve_err;
    logic [2:0]  inflight;
    logic [15:0] mispredict_cnt;

    branch_history_table #(
        .PC_W(32), .IDX_W(4), .FIFO_DEPTH(4), .INIT_STATE(2'b01)
    ) dut (
        .clk(clk), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .mispredict(mispredict), .resolve_err(resolve_err),
        .inflight(inflight), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit pred;
    } ent_t;

    int   mctr [16];
    ent_t mq [$];
    int   mcnt;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; inputs are applied 1 time unit after a rising
    // edge and outputs are sampled 1 time unit after the next rising edge.
    task automatic step(input bit rst, input bit lv, input logic [31:0] pc,
                        input bit rv, input bit rt);
        bit   acc, e_pv, e_pt, e_mis, e_err;
        int   e_pi, idx;
        ent_t e;
        reset         = rst;
        lookup_valid  = lv;
        lookup_pc     = pc;
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
        chk("lookup_ready", {31'd0, lookup_ready}, {31'd0, (mq.size() < 4)});
        e_pv = 0; e_pt = 0; e_pi = 0; e_mis = 0; e_err = 0;
        if (rst) begin
            foreach (mctr[i]) mctr[i] = 1;
            mq.delete();
            mcnt = 0;
        end else begin
            acc = lv && (mq.size() < 4);
            if (rv) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    if (rt) mctr[e.idx] = (mctr[e.idx] == 3) ? 3 : mctr[e.idx] + 1;
                    else    mctr[e.idx] = (mctr[e.idx] == 0) ? 0 : mctr[e.idx] - 1;
                    e_mis = (e.pred != rt);
                    if (e_mis && mcnt < 65535) mcnt++;
                end else begin
                    e_err = 1;
                end
            end
            if (acc) begin
                idx = (pc / 4) % 16;
                e.idx  = idx;
                e.pred = (mctr[idx] >= 2);
                mq.push_back(e);
                e_pv = 1;
                e_pt = e.pred;
                e_pi = idx;
            end
        end
        @(posedge clk);
        #1;
        chk("pred_valid", {31'd0, pred_valid}, {31'd0, e_pv});
        if (e_pv || rst) begin
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
            chk("pred_idx", {28'd0, pred_idx}, e_pi);
        end
        chk("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
        chk("resolve_err", {31'd0, resolve_err}, {31'd0, e_err});
        chk("inflight", {29'd0, inflight}, mq.size());
        chk("mispredict_cnt", {16'd0, mispredict_cnt}, mcnt);
    endtask

    initial begin
        int n;
        reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        foreach (mctr[i]) mctr[i] = 1;
        mcnt = 0;

        // Reset.
        step(1, 0, 0, 0, 0);
        step(1, 1, 32'h40, 1, 1);

        // First lookup, then retire it.
        step(0, 1, 32'h40, 0, 0);
        step(0, 0, 0, 1, 0);

        // Train idx 3: two lookups, two taken resolves, then a third lookup.
        step(0, 1, 32'h0C, 0, 0);
        step(0, 1, 32'h0C, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0C, 0, 0);
        // Saturate at 11, then walk down to 00 and past it.
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 32'h0C, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        step(0, 1, 32'h0C, 0, 0);
        step(0, 0, 0, 1, 0);

        // FIFO full, lookup held while not ready, then one resolve.
        for (int i = 0; i < 4; i++) step(0, 1, 32'h100 + 32'(i * 4), 0, 0);
        step(0, 1, 32'h20, 0, 0);
        step(0, 1, 32'h20, 1, 1);
        step(0, 1, 32'h20, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        // Bypass on idx 5.
        step(0, 1, 32'h14, 0, 0);
        step(0, 1, 32'h14, 1, 1);
        step(0, 0, 0, 1, 1);

        // Resolve on empty FIFO.
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Reset with three in flight; afterwards every counter should be 01:
        // a taken resolve bypassed into a same-index lookup must predict taken.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h08, 0, 0);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 32'(i * 4), 0, 0);
            step(0, 1, 32'(i * 4), 1, 1);
            step(0, 0, 0, 1, 0);
        end

        // Randomized traffic, narrow PC range to force index collisions.
        n = 3000;
        for (int i = 0; i < n; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 255),
                 ($urandom_range(0, 2) != 0),
                 $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Table of 2-bit saturating branch-direction counters with a lookup (predict) port and an in-order resolve (update) port. It reads and updates the per-branch 2-bit prediction state that the predictor's state registers hold. A small in-order FIFO records each prediction's index and predicted direction, so resolves need only carry the actual outcome. It sits between fetch (lookup) and execute (branch resolution).

## Interface
- PC_W, 32, lookup PC width
- IDX_W, 4, table index width; table has 2^IDX_W entries
- FIFO_DEPTH, 4, maximum in-flight predictions (power of 2, ≥2)
- INIT_STATE, 2'b01, counter value after reset (weakly not-taken)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lookup_valid  in  1  predict request
- lookup_pc  in  PC_W  branch PC; index = lookup_pc[IDX_W+1:2]
- lookup_ready  out  1  request accepted when valid && ready
- pred_valid  out  1  prediction strobe (one cycle)
- pred_taken  out  1  predicted direction
- pred_idx  out  IDX_W  index used for the prediction
- resolve_valid  in  1  oldest in-flight branch resolved
- resolve_taken  in  1  actual direction
- mispredict  out  1  registered pulse: predicted != actual
- resolve_err  out  1  registered pulse: resolve with empty FIFO
- inflight  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- mispredict_cnt  out  16  saturating mispredict count

## Operation
- Counter states: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction is bit[1].
- Reset: all counters = INIT_STATE; FIFO emptied (inflight=0); pred_valid, pred_taken, pred_idx, mispredict, resolve_err = 0; mispredict_cnt = 0. One cycle, no init sequence.
- lookup_ready = (inflight < FIFO_DEPTH), combinational from occupancy only; it does not depend on resolve_valid.
- Accepted lookup: read the counter at the index, register the prediction outputs, and push {idx, predicted bit} into the FIFO.
- Resolve with FIFO non-empty:
  - Pop the oldest entry.
  - Update its counter: taken → +1, saturating at 11; not-taken → −1, saturating at 00.
  - Set mispredict = (popped predicted bit != resolve_taken).
  - On mispredict, increment mispredict_cnt, holding at 16'hFFFF.
- Resolve with FIFO empty: resolve_err = 1; no counter, FIFO, or mispredict change.
- Simultaneous lookup and resolve:
  - Push and pop both occur; inflight is unchanged.
  - If the indices match, the lookup uses the post-update counter value (bypass).
- Two in-flight predictions to the same index each record their own predicted bit. Updates apply in resolve order to the live counter, not to a stored counter copy.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses an extra bit to tell full from empty.

## Timing
- Lookup accepted on cycle N → pred_valid, pred_taken, pred_idx valid on N+1 for exactly one cycle. pred_valid = 0 otherwise.
- Resolve on cycle N → counter updated at the N edge, visible to a lookup on cycle N via bypass. mispredict or resolve_err pulse on N+1; mispredict_cnt updated on N+1.
- inflight reflects pushes and pops of cycle N on N+1.
- Throughput: one lookup and one resolve per cycle.
- Reset asserted mid-operation: in-flight entries are discarded. Outputs read reset values from the next cycle. A resolve or lookup in the reset cycle is ignored. The cycle after reset deasserts, lookup_ready = 1.

## Test plan
- Reset, then lookup PC 0x40 (idx 0) → pred_valid=1, pred_taken=0 on the next cycle; inflight=1.
- Train idx 3 (PC 0x0C):
  - Lookup + resolve taken ×2 → counter 01→10→11.
  - Third lookup → pred_taken=1.
  - First resolve → mispredict=1 (predicted 0, actual 1); second resolve → mispredict=0.
  - mispredict_cnt=1.
- Saturation:
  - Counter at 11, resolve taken → stays 11.
  - Drive to 00 with three NT resolves, one more NT → stays 00, pred_taken=0.
- FIFO full: 4 lookups, no resolve → inflight=4, lookup_ready=0. Lookup_valid held → no pred_valid. One resolve → ready=1 the next cycle.
- Bypass: counter 01 at idx 5, resolve taken (predicted 0) and lookup PC 0x14 on the same cycle → pred_taken=1, mispredict=1, inflight unchanged.
- Errors and reset:
  - Resolve with inflight=0 → resolve_err=1 one cycle, mispredict_cnt unchanged.
  - Reset with inflight=3 → inflight=0, all counters back to 01.
